// File: rtl/posit_arb_pkg.sv
// Shared types for the posit adder arbiter: FSM states, issue tag and clog2.
package posit_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Sized for the largest supported requester count (8); unused upper id bits stay 0.
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/posit_add_arbiter_rr.sv
// Round-robin grant: combinational one-hot winner among req, searching from the slot after the last grant.
// Pointer moves to the granted index on advance; resets to NREQ-1 so requester 0 wins first.
module rr_arbiter
  import posit_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          grant,
  output logic [clog2(NREQ)-1:0]   grant_idx
);

  localparam int IW = clog2(NREQ);

  logic [IW-1:0] ptr;

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr <= IW'(NREQ - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/posit_add_arbiter.sv
// Round-robin front end sharing one pipelined posit adder among NREQ requesters (optional stats: POSIT_ARB_STATS_EN).
// Latency: handshake to rsp_valid is LAT+1 cycles; one issue per cycle sustained.
// Backpressure: requests wait on req_ready; results have none and are broadcast with a one-hot rsp_valid.
module posit_add_arbiter
  import posit_arb_pkg::*;
#(
  parameter int N    = 32,
  parameter int ES   = 2,
  parameter int NREQ = 4,
  parameter int LAT  = 6
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_in1,
  input  logic [NREQ*N-1:0] req_in2,
  output logic [N-1:0]      add_in1,
  output logic [N-1:0]      add_in2,
  output logic              add_start,
  input  logic [N-1:0]      add_result,
  input  logic              add_inf,
  input  logic              add_zero,
  input  logic              add_done,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_result,
  output logic              rsp_inf,
  output logic              rsp_zero,
  output logic              busy,
  output logic              tag_err
`ifdef POSIT_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_grants,
  output logic [15:0]        stat_stall
`endif
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(LAT + 2);

  if (NREQ < 2 || NREQ > 8 || ES < 0) begin : g_param_err
    $error("posit_add_arbiter: NREQ must be 2..8 and ES non-negative");
  end

  state_t          state, state_nxt;
  logic [NREQ-1:0] arb_req, grant;
  logic [IW-1:0]   grant_idx;
  logic            hs;
  tag_t            tags [0:LAT];
  tag_t            tail;
  logic [CW-1:0]   cnt, cnt_nxt;

  assign arb_req = (state == RUN) ? req_valid : '0;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .aclk      (aclk),
    .areset    (areset),
    .req       (arb_req),
    .advance   (hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign hs        = |grant;
  assign busy      = (state != IDLE);
  assign tail      = tags[LAT];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      add_in1   <= '0;
      add_in2   <= '0;
      add_start <= 1'b0;
    end else begin
      add_start <= hs;
      if (hs) begin
        add_in1 <= req_in1[int'(grant_idx)*N +: N];
        add_in2 <= req_in2[int'(grant_idx)*N +: N];
      end
    end
  end

  // Tag pipe is LAT+1 deep: the issue register adds one stage in front of the adder.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i <= LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{vld: hs, id: TAG_ID_W'(grant_idx)};
      for (int i = 1; i <= LAT; i++) tags[i] <= tags[i-1];
    end
  end

  assign rsp_valid  = (add_done && tail.vld) ? (NREQ'(1) << tail.id) : '0;
  assign rsp_result = add_result;
  assign rsp_inf    = add_inf;
  assign rsp_zero   = add_zero;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tag_err <= 1'b0;
    end else if (add_done != tail.vld) begin
      tag_err <= 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (hs && !tail.vld) begin
      cnt_nxt = cnt + 1'b1;
    end else if (!hs && tail.vld) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt   <= '0;
      state <= IDLE;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  // Exit decisions use the post-update count so a same-cycle issue or retire is included.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = (cnt_nxt != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (en) state_nxt = RUN;
        else if (cnt_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef POSIT_ARB_STATS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && stat_grants[i*16 +: 16] != 16'hFFFF)
          stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
      end
      if (state == RUN && |req_valid && !hs && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Scoreboard bench: a behavioural posit adder stub feeds the arbiter; expected grants/results are queued at stimulus time.
module tb_posit_add_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 6;

  logic              aclk = 1'b0;
  logic              areset;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_in1, req_in2;
  logic [N-1:0]      add_in1, add_in2, add_result;
  logic              add_start, add_inf, add_zero, add_done;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_result;
  logic              rsp_inf, rsp_zero, busy, tag_err;
`ifdef POSIT_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
  logic [15:0]        stat_stall;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_on = 1'b1;
  logic inj_done = 1'b0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  posit_add_arbiter #(.N(N), .ES(2), .NREQ(NREQ), .LAT(LAT)) dut (
    .aclk(aclk), .areset(areset), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
    .busy(busy), .tag_err(tag_err)
`ifdef POSIT_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Posit<32,2> decode/encode for positive values, used by the adder stub.
  function automatic real p2r(input logic [31:0] p);
    int i, m, k, e, sc;
    real f, w, s;
    logic r0;
    if (p == 32'h0) return 0.0;
    i = 30; r0 = p[30]; m = 0;
    while (i >= 0 && p[i] == r0) begin m++; i--; end
    i--;
    k = r0 ? m - 1 : -m;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((i >= 0 && p[i]) ? 1 : 0);
      i--;
    end
    f = 1.0; w = 0.5;
    while (i >= 0) begin
      if (p[i]) f = f + w;
      w = w / 2.0; i--;
    end
    sc = 4 * k + e;
    s = 1.0;
    for (int j = 0; j < sc; j++) s = s * 2.0;
    for (int j = 0; j > sc; j--) s = s / 2.0;
    return f * s;
  endfunction

  function automatic logic [31:0] r2p(input real v);
    int sc, k, e, nb;
    real f;
    logic [63:0] acc;
    if (v == 0.0) return 32'h0;
    sc = 0; f = v;
    while (f >= 2.0) begin f = f / 2.0; sc++; end
    while (f < 1.0) begin f = f * 2.0; sc--; end
    k = (sc >= 0) ? sc / 4 : -((-sc + 3) / 4);
    e = sc - 4 * k;
    acc = '0; nb = 0;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) begin acc = {acc[62:0], 1'b1}; nb++; end
      acc = {acc[62:0], 1'b0}; nb++;
    end else begin
      for (int i = 0; i < -k; i++) begin acc = {acc[62:0], 1'b0}; nb++; end
      acc = {acc[62:0], 1'b1}; nb++;
    end
    acc = {acc[61:0], 2'(e)}; nb += 2;
    f = f - 1.0;
    while (nb < 31) begin
      f = f * 2.0;
      acc = {acc[62:0], (f >= 1.0)};
      if (f >= 1.0) f = f - 1.0;
      nb++;
    end
    return {1'b0, 31'(acc >> (nb - 31))};
  endfunction

  // Adder stub: LAT-cycle pipeline, reset together with the arbiter.
  logic        p_vld [LAT];
  logic [31:0] p_res [LAT];
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < LAT; i++) begin p_vld[i] <= 1'b0; p_res[i] <= '0; end
    end else begin
      p_vld[0] <= add_start;
      p_res[0] <= r2p(p2r(add_in1) + p2r(add_in2));
      for (int i = 1; i < LAT; i++) begin p_vld[i] <= p_vld[i-1]; p_res[i] <= p_res[i-1]; end
    end
  end
  assign add_done   = p_vld[LAT-1] | inj_done;
  assign add_result = inj_done ? 32'h1234_5678 : p_res[LAT-1];
  assign add_inf    = (add_result == 32'h8000_0000);
  assign add_zero   = (add_result == 32'h0);

  int          exp_gnt[$];
  int          exp_id[$];
  logic [31:0] exp_res[$];
  int          hs_cyc[$];
  int          st_cyc[$];
  logic [31:0] st_a[$], st_b[$];

  logic [NREQ-1:0] m_hv;
  int m_gi, m_id, m_hc;

  always @(negedge aclk) begin
    if (!areset && mon_on) begin
      m_hv = req_valid & req_ready;
      if (m_hv != '0) begin
        m_gi = 0;
        for (int i = 0; i < NREQ; i++) if (m_hv[i]) m_gi = i;
        chk("gnt_onehot", $countones(m_hv), 1);
        if (exp_gnt.size() == 0) chk("gnt_unexp", m_hv, 0);
        else chk("gnt_order", m_gi, exp_gnt.pop_front());
        hs_cyc.push_back(cyc);
        st_cyc.push_back(cyc + 1);
        st_a.push_back(req_in1[m_gi*N +: N]);
        st_b.push_back(req_in2[m_gi*N +: N]);
      end
      if (st_cyc.size() > 0 && st_cyc[0] == cyc) begin
        chk("add_start", add_start, 1);
        chk("add_in1", add_in1, st_a.pop_front());
        chk("add_in2", add_in2, st_b.pop_front());
        void'(st_cyc.pop_front());
      end else if (add_start) begin
        chk("start_unexp", add_start, 0);
      end
      if (rsp_valid != '0) begin
        if (exp_id.size() == 0) begin
          chk("rsp_unexp", rsp_valid, 0);
        end else begin
          m_id = exp_id.pop_front();
          m_hc = (hs_cyc.size() > 0) ? hs_cyc.pop_front() : -100;
          chk("rsp_onehot", rsp_valid, 64'(1) << m_id);
          chk("rsp_result", rsp_result, exp_res.pop_front());
          chk("rsp_lat", cyc - m_hc, LAT + 1);
          chk("rsp_flags", {rsp_inf, rsp_zero}, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic flush_q();
    exp_gnt.delete(); exp_id.delete(); exp_res.delete();
    hs_cyc.delete(); st_cyc.delete(); st_a.delete(); st_b.delete();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #1;
    flush_q();
    tick(2);
    areset = 1'b0;
  endtask

  task automatic chk_outs_zero();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag_err", tag_err, 0);
    chk("rst_add_in1", add_in1, 0);
    chk("rst_add_in2", add_in2, 0);
  endtask

  task automatic wait_empty(input int n);
    for (int i = 0; i < n && exp_id.size() > 0; i++) tick(1);
    tick(1);
    chk("drain_timeout", exp_id.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr;
    bit done;
    areset = 1'b1; en = 1'b0; req_valid = '0; req_in1 = '0; req_in2 = '0;
    #2;
    chk_outs_zero();
    tick(2);
    areset = 1'b0;

    // S1: single requester 2, 1.0 + 1.0
    do_reset();
    en = 1'b1;
    tick(2);
    req_in1[2*N +: N] = 32'h4000_0000;
    req_in2[2*N +: N] = 32'h4000_0000;
    exp_gnt.push_back(2); exp_id.push_back(2); exp_res.push_back(32'h4800_0000);
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    wait_empty(20);

    // S2: all requesters continuously valid for 8 grants
    do_reset();
    en = 1'b1;
    tick(2);
    for (int i = 0; i < NREQ; i++) begin
      req_in1[i*N +: N] = r2p(real'(i + 1));
      req_in2[i*N +: N] = r2p(1.0);
    end
    for (int k = 0; k < 8; k++) begin
      exp_gnt.push_back(k % 4); exp_id.push_back(k % 4); exp_res.push_back(r2p(real'(k % 4 + 2)));
    end
    req_valid = 4'hF;
    tick(8);
    req_valid = '0;
    wait_empty(30);
    chk("s2_tag_err", tag_err, 0);

    // S3: 5 back-to-back issues, then drain
    do_reset();
    en = 1'b1;
    tick(2);
    for (int k = 0; k < 5; k++) begin
      req_in1[0 +: N] = r2p(real'(k + 1));
      req_in2[0 +: N] = r2p(2.0);
      exp_gnt.push_back(0); exp_id.push_back(0); exp_res.push_back(r2p(real'(k + 3)));
      req_valid = 4'b0001;
      tick(1);
    end
    req_valid = '0;
    en = 1'b0;
    tick(1);
    chk("s3_busy_drain", busy, 1);
    req_valid = 4'hF;
    nr = 0; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      chk("s3_no_ready", req_ready, 0);
      if (rsp_valid != '0) begin
        nr++;
        if (nr == 5) begin
          chk("s3_busy_last", busy, 1);
          tick(1);
          chk("s3_idle", busy, 0);
          done = 1'b1;
        end
      end
      if (!done) tick(1);
    end
    chk("s3_rsp_count", nr, 5);
    req_valid = '0;
    tick(2);

    // S4: spurious add_done with empty tag pipe
    inj_done = 1'b1;
    #2;
    chk("s4_rsp_valid", rsp_valid, 0);
    tick(1);
    inj_done = 1'b0;
    chk("s4_tag_err", tag_err, 1);
    tick(5);
    chk("s4_tag_err_sticky", tag_err, 1);

    // S5: reset with 3 ops in flight
    do_reset();
    chk("s5_tag_err_clr", tag_err, 0);
    en = 1'b1;
    tick(2);
    req_in1[3*N +: N] = r2p(1.0);
    req_in2[3*N +: N] = r2p(1.0);
    for (int k = 0; k < 3; k++) exp_gnt.push_back(3);
    req_valid = 4'b1000;
    tick(3);
    req_valid = '0;
    tick(2);
    areset = 1'b1;
    #1;
    chk_outs_zero();
    flush_q();
    tick(2);
    areset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("s5_no_rsp", rsp_valid, 0);
      tick(1);
    end
    chk("s5_tag_err", tag_err, 0);
    req_in1[0 +: N] = r2p(2.0);
    req_in2[0 +: N] = r2p(2.0);
    exp_gnt.push_back(0); exp_id.push_back(0); exp_res.push_back(r2p(4.0));
    req_valid = 4'hF;
    tick(1);
    req_valid = '0;
    wait_empty(20);

`ifdef POSIT_ARB_STATS_EN
    // S6: grant counter saturation
    do_reset();
    mon_on = 1'b0;
    en = 1'b1;
    tick(2);
    req_valid = 4'b0010;
    tick(70000);
    req_valid = '0;
    chk("s6_sat", stat_grants[31:16], 16'hFFFF);
    chk("s6_g0", stat_grants[15:0], 0);
    tick(10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/posit_add_arbiter.md
POSIT_ADD_ARBITER -- requirements
Module: posit_add_arbiter

Interface
REQ-001 Param N, 32, posit word width.
REQ-002 Param ES, 2, exponent field width; forwarded to the adder instance by the integrator and not used internally.
REQ-003 Param NREQ, 4, number of requesters (2..8).
REQ-004 Param LAT, 6, adder start-to-done latency in cycles.
REQ-005 aclk  in  1  clock; all logic on the rising edge.
REQ-006 areset  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  grant enable; 0 requests a drain.
REQ-008 req_valid  in  NREQ  per-requester operand valid.
REQ-009 req_ready  out  NREQ  per-requester grant; the handshake completes when req_valid&req_ready are both 1.
REQ-010 req_in1, req_in2  in  NREQ*N each  packed operands; requester i occupies bits [i*N +: N].
REQ-011 add_in1, add_in2  out  N each  adder operands.
REQ-012 add_start  out  1  adder issue strobe.
REQ-013 add_result  in  N; add_inf, add_zero, add_done  in  1 each  adder outputs.
REQ-014 rsp_valid  out  NREQ  one-hot result strobe.
REQ-015 rsp_result  out  N; rsp_inf, rsp_zero  out  1 each  result broadcast to all requesters.
REQ-016 busy  out  1  high when the state is not IDLE.
REQ-017 tag_err  out  1  sticky error flag.

Function
REQ-018 The arbiter SHALL grant at most one requester per cycle, combinationally, round-robin, starting the search at the index after the last granted requester.
REQ-019 After reset, requester 0 SHALL have highest priority.
REQ-020 req_ready[i] SHALL be asserted only when the state is RUN and i is the round-robin winner among the asserted req_valid bits.
REQ-021 req_ready SHALL be 0 in IDLE and DRAIN.
REQ-022 On a handshake, add_in1/add_in2/add_start SHALL be registered: the granted operands plus start=1 appear on the next cycle; start=0 otherwise.
REQ-023 add_in1/add_in2 SHALL hold their last values when no handshake occurs.
REQ-024 A tag shift register, {valid, id[clog2(NREQ)-1:0]} and LAT+1 deep, SHALL track every issue so that its tail aligns with add_done.
REQ-025 When add_done=1 and the tail tag is valid, rsp_valid[tag.id] SHALL be set in the same cycle and rsp_result/rsp_inf/rsp_zero SHALL pass through combinationally.
REQ-026 Total latency from handshake to rsp_valid SHALL be LAT+1 cycles.
REQ-027 If add_done differs from the tail valid bit, tag_err SHALL set and stay set until reset; rsp_valid SHALL stay 0 in that cycle.
REQ-028 An in-flight counter of width clog2(LAT+2) SHALL increment on issue and decrement on tail-valid.
REQ-029 When issue and tail-valid occur in the same cycle, the in-flight counter SHALL be unchanged.
REQ-030 The counter SHALL never wrap: a full pipeline accepts one issue per cycle indefinitely.
REQ-031 The FSM SHALL have three states: IDLE, RUN, DRAIN.
REQ-032 IDLE->RUN when en=1.
REQ-033 RUN->DRAIN when en=0 and in-flight!=0 (counting an issue made in the same cycle); RUN->IDLE when en=0 and in-flight==0.
REQ-034 DRAIN->IDLE when in-flight==0 and no tail-valid is pending; DRAIN->RUN when en=1.
REQ-035 There SHALL be no backpressure on results; requesters SHALL sample rsp_* whenever their rsp_valid bit is 1.

Reset
REQ-036 areset SHALL immediately clear state to IDLE, req_ready/rsp_valid/add_start/busy/tag_err to 0, add_in1/add_in2 to 0, all tags to invalid, the in-flight counter to 0, and the round-robin pointer to NREQ-1.
REQ-037 Operations in flight at reset SHALL be discarded; adder done pulses arriving after reset with invalid tags SHALL set tag_err unless the adder is reset too.

Configuration
REQ-038 With POSIT_ARB_STATS_EN defined, the block SHALL add output stat_grants (NREQ*16), with one saturating 16-bit handshake counter per requester, cleared by areset.
REQ-039 With POSIT_ARB_STATS_EN defined, the block SHALL add output stat_stall (16), a saturating count of cycles in RUN with req_valid!=0 and no grant.
REQ-040 Without POSIT_ARB_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-041 Package posit_arb_pkg SHALL hold the state enum (IDLE, RUN, DRAIN), the tag struct, and the function clog2.
REQ-042 One sub-module, rr_arbiter (NREQ parameter, req in, grant out, advance strobe), SHALL implement the pointer and the grant logic.

Verification
REQ-043 Scenario 1: en=1, requester 2 alone issues in1=0x40000000, in2=0x40000000 -> add_start at cycle+1; rsp_valid=4'b0100 at cycle+7 with the behavioural-model sum 0x48000000.
REQ-044 Scenario 2: all 4 requesters continuously valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses in the same order at LAT+1 spacing; tag_err=0.
REQ-045 Scenario 3: 5 issues back-to-back, then en=0 -> state DRAIN, busy=1 until the 5th response, then IDLE on the next cycle; no req_ready while in DRAIN.
REQ-046 Scenario 4: with a stub adder, inject a spurious add_done with an empty tag pipe -> tag_err=1 and stays 1; rsp_valid=0.
REQ-047 Scenario 5: assert areset with 3 ops in flight -> all outputs 0 immediately; no rsp_valid for the discarded ops with the adder also reset; next grant goes to requester 0.
REQ-048 Scenario 6 (POSIT_ARB_STATS_EN): 70000 grants to requester 1 -> stat_grants[1] saturates at 0xFFFF.
